// File: rtl/alu_pkg.sv
// Shared opcode, FSM state and error-pattern definitions for the EX-stage ALU/MDU.
package alu_pkg;

    localparam logic [3:0] ALU_OP_AND   = 4'b0000;
    localparam logic [3:0] ALU_OP_OR    = 4'b0001;
    localparam logic [3:0] ALU_OP_ADD   = 4'b0010;
    localparam logic [3:0] ALU_OP_SRAV  = 4'b0011;
    localparam logic [3:0] ALU_OP_SUB   = 4'b0110;
    localparam logic [3:0] ALU_OP_SLT   = 4'b0111;
    localparam logic [3:0] ALU_OP_XOR   = 4'b1000;
    localparam logic [3:0] ALU_OP_NOR   = 4'b1001;
    localparam logic [3:0] ALU_OP_SLLV  = 4'b1010;
    localparam logic [3:0] ALU_OP_SRLV  = 4'b1011;
    localparam logic [3:0] ALU_OP_MULT  = 4'b1100;
    localparam logic [3:0] ALU_OP_MULTU = 4'b1101;
    localparam logic [3:0] ALU_OP_DIV   = 4'b1110;
    localparam logic [3:0] ALU_OP_DIVU  = 4'b1111;

    localparam logic [31:0] ERR_PATTERN = 32'hDEADBEEF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/mdu_iter.sv
// Iterative unsigned multiply (shift-add) / restoring divide, one bit per cycle.
// hi/lo present the value produced by the current step, so they are final while done is high.
module mdu_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a_mag,
    input  logic [WIDTH-1:0] b_mag,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic             busy;
    logic             div_mode;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] acc, q, m;
    logic [WIDTH-1:0] nxt_acc, nxt_q;
    logic [WIDTH:0]   sum, tmp, diff;

    always_comb begin
        sum  = {1'b0, acc} + (q[0] ? {1'b0, m} : '0);
        tmp  = {acc, q[WIDTH-1]};
        diff = tmp - {1'b0, m};
        if (div_mode) begin
            // Partial remainder is always below the divisor, so both branches fit WIDTH bits.
            if (!diff[WIDTH]) begin
                nxt_acc = diff[WIDTH-1:0];
                nxt_q   = {q[WIDTH-2:0], 1'b1};
            end else begin
                nxt_acc = tmp[WIDTH-1:0];
                nxt_q   = {q[WIDTH-2:0], 1'b0};
            end
        end else begin
            nxt_acc = sum[WIDTH:1];
            nxt_q   = {sum[0], q[WIDTH-1:1]};
        end
    end

    assign done = busy && (cnt == CNT_W'(1));
    assign hi   = nxt_acc;
    assign lo   = nxt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            busy     <= 1'b0;
            div_mode <= 1'b0;
            cnt      <= '0;
            acc      <= '0;
            q        <= '0;
            m        <= '0;
        end else if (start) begin
            busy     <= 1'b1;
            div_mode <= is_div;
            cnt      <= CNT_W'(WIDTH);
            acc      <= '0;
            q        <= a_mag;
            m        <= b_mag;
        end else if (busy) begin
            acc <= nxt_acc;
            q   <= nxt_q;
            cnt <= cnt - CNT_W'(1);
            if (done) busy <= 1'b0;
        end
    end

endmodule

// File: rtl/alu_mdu.sv
// Registered MIPS ALU with valid/ready handshake and iterative MULT/DIV producing HI/LO.
module alu_mdu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       alu_control,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] hi,
    output logic             zero,
    output logic             err
);
    localparam int SHAMT_W = $clog2(WIDTH);

    state_t           state;
    logic             neg_q, neg_r, div0;
    logic [WIDTH-1:0] a_r;

    logic               accept, is_mdu, is_div, sgn, a_neg, b_neg, start;
    logic [WIDTH-1:0]   a_mag, b_mag, c_hi, c_lo, err_val;
    logic               c_done;
    logic [SHAMT_W-1:0] shamt;
    logic [WIDTH-1:0]   alu_val, md_lo, md_hi;
    logic               alu_err;
    logic [2*WIDTH-1:0] prod;

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);
    assign accept    = in_valid && in_ready;
    assign is_mdu    = (alu_control[3:2] == 2'b11);
    assign is_div    = (alu_control[3:1] == 3'b111);
    assign sgn       = is_mdu && !alu_control[0];
    assign a_neg     = sgn && a[WIDTH-1];
    assign b_neg     = sgn && b[WIDTH-1];
    assign a_mag     = a_neg ? -a : a;
    assign b_mag     = b_neg ? -b : b;
    assign start     = accept && is_mdu;
    assign shamt     = a[SHAMT_W-1:0];
    assign err_val   = WIDTH'(ERR_PATTERN);

    mdu_iter #(.WIDTH(WIDTH)) u_iter (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .is_div (is_div),
        .a_mag  (a_mag),
        .b_mag  (b_mag),
        .done   (c_done),
        .hi     (c_hi),
        .lo     (c_lo)
    );

    always_comb begin
        alu_val = '0;
        alu_err = 1'b0;
        case (alu_control)
            ALU_OP_ADD:  alu_val = a + b;
            ALU_OP_SUB:  alu_val = a - b;
            ALU_OP_AND:  alu_val = a & b;
            ALU_OP_OR:   alu_val = a | b;
            ALU_OP_XOR:  alu_val = a ^ b;
            ALU_OP_NOR:  alu_val = ~(a | b);
            ALU_OP_SLT:  alu_val = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
            ALU_OP_SLLV: alu_val = b << shamt;
            ALU_OP_SRLV: alu_val = b >> shamt;
            ALU_OP_SRAV: alu_val = $signed(b) >>> shamt;
            ALU_OP_MULT, ALU_OP_MULTU, ALU_OP_DIV, ALU_OP_DIVU: alu_val = '0;
            default: begin
                alu_val = err_val;
                alu_err = 1'b1;
            end
        endcase
    end

    // Sign fix-up: quotient truncates toward zero, remainder follows the dividend.
    always_comb begin
        prod = {c_hi, c_lo};
        prod = neg_q ? -prod : prod;
        md_lo = prod[WIDTH-1:0];
        md_hi = prod[2*WIDTH-1:WIDTH];
        if (state == ST_DIV) begin
            if (div0) begin
                md_lo = '1;
                md_hi = a_r;
            end else begin
                md_lo = neg_q ? -c_lo : c_lo;
                md_hi = neg_r ? -c_hi : c_hi;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            result <= '0;
            hi     <= '0;
            zero   <= 1'b0;
            err    <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            div0   <= 1'b0;
            a_r    <= '0;
        end else begin
            case (state)
                ST_IDLE: if (accept) begin
                    if (is_mdu) begin
                        neg_q <= a_neg ^ b_neg;
                        neg_r <= a_neg;
                        div0  <= (b == '0);
                        a_r   <= a;
                        state <= is_div ? ST_DIV : ST_MUL;
                    end else begin
                        result <= alu_val;
                        hi     <= '0;
                        zero   <= (alu_val == '0);
                        err    <= alu_err;
                        state  <= ST_DONE;
                    end
                end
                ST_MUL, ST_DIV: if (c_done) begin
                    result <= md_lo;
                    hi     <= md_hi;
                    zero   <= (md_lo == '0);
                    err    <= 1'b0;
                    state  <= ST_DONE;
                end
                ST_DONE: if (out_ready) state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mdu.sv
// Directed self-checking bench for alu_mdu (WIDTH=32) with hand-computed expected values.
module tb_alu_mdu;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a, b;
    logic [3:0]  alu_control;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result, hi;
    logic        zero, err;

    int checks = 0;
    int errors = 0;

    alu_mdu #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a           (a),
        .b           (b),
        .alu_control (alu_control),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result),
        .hi          (hi),
        .zero        (zero),
        .err         (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_ready"}, {63'd0, in_ready}, 64'd1);
    endtask

    task automatic run(input string tag, input logic [3:0] op, input logic [31:0] ta,
                       input logic [31:0] tb2, input int exp_lat, input logic [31:0] er,
                       input logic [31:0] eh, input logic ee);
        int lat;
        wait_idle(tag);
        in_valid = 1'b1; a = ta; b = tb2; alu_control = op;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        chk({tag, "_res"}, {32'd0, result}, {32'd0, er});
        chk({tag, "_hi"}, {32'd0, hi}, {32'd0, eh});
        chk({tag, "_zero"}, {63'd0, zero}, {63'd0, (er == 32'd0)});
        chk({tag, "_err"}, {63'd0, err}, {63'd0, ee});
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; alu_control = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        chk("rst_ov", {63'd0, out_valid}, 64'd0);
        chk("rst_ir", {63'd0, in_ready}, 64'd1);
        chk("rst_res", {32'd0, result}, 64'd0);
        chk("rst_hi", {32'd0, hi}, 64'd0);
        chk("rst_zero", {63'd0, zero}, 64'd0);
        chk("rst_err", {63'd0, err}, 64'd0);

        run("add", 4'b0010, 32'd5, 32'd7, 1, 32'd12, 32'd0, 1'b0);
        run("sub", 4'b0110, 32'd7, 32'd7, 1, 32'd0, 32'd0, 1'b0);
        run("and", 4'b0000, 32'h0000F0F0, 32'h0000FF00, 1, 32'h0000F000, 32'd0, 1'b0);
        run("or",  4'b0001, 32'h0000F0F0, 32'h0000FF00, 1, 32'h0000FFF0, 32'd0, 1'b0);
        run("xor", 4'b1000, 32'h0000F0F0, 32'h0000FF00, 1, 32'h00000FF0, 32'd0, 1'b0);
        run("nor", 4'b1001, 32'd0, 32'd0, 1, 32'hFFFFFFFF, 32'd0, 1'b0);
        run("sllv", 4'b1010, 32'd4, 32'd1, 1, 32'h00000010, 32'd0, 1'b0);
        run("srlv", 4'b1011, 32'd31, 32'h80000000, 1, 32'h00000001, 32'd0, 1'b0);
        run("srav", 4'b0011, 32'd4, 32'h80000000, 1, 32'hF8000000, 32'd0, 1'b0);
        run("ill4", 4'b0100, 32'd1, 32'd2, 1, 32'hDEADBEEF, 32'd0, 1'b1);
        run("ill5", 4'b0101, 32'd1, 32'd2, 1, 32'hDEADBEEF, 32'd0, 1'b1);
        run("mult", 4'b1100, 32'hFFFFFFFD, 32'd7, 33, 32'hFFFFFFEB, 32'hFFFFFFFF, 1'b0);
        run("multu", 4'b1101, 32'hFFFFFFFD, 32'd7, 33, 32'hFFFFFFEB, 32'h00000006, 1'b0);
        run("div", 4'b1110, 32'hFFFFFFF9, 32'd2, 33, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0);
        run("divu0", 4'b1111, 32'h00000064, 32'd0, 33, 32'hFFFFFFFF, 32'h00000064, 1'b0);
        run("divovf", 4'b1110, 32'h80000000, 32'hFFFFFFFF, 33, 32'h80000000, 32'd0, 1'b0);
        run("divu", 4'b1111, 32'd100, 32'd7, 33, 32'd14, 32'd2, 1'b0);

        // Backpressure: result held while out_ready is low, further requests ignored.
        wait_idle("bp");
        out_ready = 1'b0;
        in_valid = 1'b1; a = 32'hFFFFFFFF; b = 32'd1; alu_control = 4'b0111;
        @(posedge clk); #1;
        chk("bp_ov0", {63'd0, out_valid}, 64'd1);
        chk("bp_res0", {32'd0, result}, 64'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1; a = 32'd9; b = 32'd9; alu_control = 4'b0010;
            @(posedge clk); #1;
            chk("bp_ov", {63'd0, out_valid}, 64'd1);
            chk("bp_res", {32'd0, result}, 64'd1);
            chk("bp_ir", {63'd0, in_ready}, 64'd0);
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_rel_ov", {63'd0, out_valid}, 64'd0);
        chk("bp_rel_ir", {63'd0, in_ready}, 64'd1);

        // Reset during a divide aborts it.
        wait_idle("abort");
        in_valid = 1'b1; a = 32'd1000; b = 32'd3; alu_control = 4'b1110;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        chk("abort_ov", {63'd0, out_valid}, 64'd0);
        chk("abort_ir", {63'd0, in_ready}, 64'd1);
        chk("abort_res", {32'd0, result}, 64'd0);
        @(negedge clk); rst = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            chk("abort_nopulse", {63'd0, out_valid}, 64'd0);
        end
        run("post_add", 4'b0010, 32'd1, 32'd1, 1, 32'd2, 32'd0, 1'b0);

        // Accept coinciding with reset is discarded.
        wait_idle("rstacc");
        rst = 1'b1; in_valid = 1'b1; a = 32'd3; b = 32'd4; alu_control = 4'b0010;
        @(posedge clk); #1;
        chk("rstacc_ov", {63'd0, out_valid}, 64'd0);
        chk("rstacc_ir", {63'd0, in_ready}, 64'd1);
        chk("rstacc_res", {32'd0, result}, 64'd0);
        @(negedge clk); rst = 1'b0; in_valid = 1'b0;
        @(posedge clk); #1;
        chk("rstacc_ov2", {63'd0, out_valid}, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_mdu.md
Name: alu_mdu

Overview:
- Parametrised, registered successor to the combinational MIPS ALU.
- Adds a valid/ready handshake on input and output, plus the SRAV op.
- Adds iterative multi-cycle MULT/MULTU/DIV/DIVU that produce a HI/LO pair.
- Sits in the EX stage; the pipeline stalls on in_ready/out_valid.

Parameters:
- WIDTH, 32, datapath width in bits (≥8, power of two).
- SHAMT_W, $clog2(WIDTH), shift-amount width (derived localparam, not overridable).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand/opcode valid.
- in_ready  out  1  block can accept an operation.
- a  in  WIDTH  operand A (shift amount for shifts).
- b  in  WIDTH  operand B.
- alu_control  in  4  opcode.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- result  out  WIDTH  result, or LO (product low / quotient).
- hi  out  WIDTH  product high / remainder; 0 for single-cycle ops.
- zero  out  1  result == 0 (registered with result).
- err  out  1  illegal opcode flag.

Behaviour:
- Opcodes (unchanged from the previous generation):
  - ADD 0010, SUB 0110, AND 0000, OR 0001, SLT 0111 (signed), XOR 1000, NOR 1001.
  - SLLV 1010: b << a[SHAMT_W-1:0].
  - SRLV 1011: b >> a[SHAMT_W-1:0].
- New opcodes:
  - SRAV 0011: arithmetic right shift of b by a[SHAMT_W-1:0].
  - MULT 1100, MULTU 1101, DIV 1110, DIVU 1111.
- Illegal opcodes (0100, 0101): result = 32'hDEADBEEF truncated/zero-extended to WIDTH, hi = 0, err = 1. err = 0 for all legal ops.
- FSM states: IDLE, MUL, DIV, DONE.
  - IDLE: in_ready = 1. An accept (in_valid & in_ready) captures a, b and opcode.
    - Single-cycle or illegal op → DONE.
    - MULT/MULTU → MUL.
    - DIV/DIVU → DIV.
  - MUL/DIV: shift-add multiply or restoring divide, one bit per cycle. An iteration counter runs WIDTH cycles, then → DONE.
  - DONE: out_valid = 1. When out_ready = 1 → IDLE.
  - in_ready = 0 in every state except IDLE. in_valid is ignored while in_ready = 0.
- Latency (accept edge to out_valid high):
  - single-cycle ops: 1 cycle.
  - mul/div: WIDTH+1 cycles.
  - Throughput: one op per (latency + 1) cycles when out_ready is held high.
- Hold rule: result, hi, zero and err stay stable while out_valid = 1 and out_ready = 0.
- Signed operations:
  - Operands are sign-magnitude converted before iteration and corrected after.
  - Signed product is the full 2·WIDTH-bit two's complement value.
  - Quotient truncates toward zero; remainder takes the sign of the dividend.
- Divide by zero (DIV or DIVU): result = all ones, hi = a. No error flag.
- Signed overflow (a = MIN, b = −1): result = MIN, hi = 0.
- Reset values: state = IDLE, out_valid = 0, in_ready = 1 (first cycle after reset), result = 0, hi = 0, zero = 0, err = 0, iteration counter = 0.
- Reset mid-operation aborts the operation. No out_valid pulse is generated for it.
- An accept in the same cycle as rst is discarded.
- No X propagation: internal registers are fully reset.

Decomposition:
- Shared package/include alu_pkg:
  - opcode constants ALU_OP_*.
  - FSM state encoding.
  - ERR_PATTERN constant.
- Sub-module mdu_iter: iterative unsigned multiply/divide core.
  - Ports: clk, rst, start, is_div, WIDTH-bit magnitudes in, done, hi/lo out.
  - Sign fix-up and single-cycle ops stay in alu_mdu.

Test Plan:
- ADD a=5, b=7, out_ready=1 → out_valid 1 cycle after accept, result=12, zero=0, hi=0. Then SUB 7−7 → result=0, zero=1.
- MULT a=FFFFFFFD, b=7 → out_valid 33 cycles after accept, result=FFFFFFEB, hi=FFFFFFFF. MULTU with the same operands → result=FFFFFFEB, hi=00000006.
- DIV a=FFFFFFF9 (−7), b=2 → result=FFFFFFFD, hi=FFFFFFFF. DIVU a=0x64, b=0 → result=FFFFFFFF, hi=00000064. DIV a=80000000, b=FFFFFFFF → result=80000000, hi=0.
- SRAV a=4, b=80000000 → result=F8000000. Opcode 0100 → result=DEADBEEF, err=1.
- Backpressure: out_ready=0 for 5 cycles after an SLT (−1 < 1) → result=1 held stable, in_ready=0, a new in_valid is not accepted. out_ready=1 → IDLE next cycle.
- rst asserted at iteration 10 of a DIV → next cycle out_valid=0, in_ready=1, result=0. A following ADD 1+1 returns 2 with normal latency.
